// File: rtl/gpio_input_conditioner.sv
// -----------------------------------------------------------------------------
// gpio_input_conditioner
//
// Purpose:
//   Conditions raw, asynchronous GPIO pad inputs before they reach the GPIO
//   slave's gpio_in bus. Each bit passes through a two-flop synchronizer and
//   is then debounced against a shared prescaled sample tick. The block
//   outputs a clean level for each bit. It also outputs single-cycle rise and
//   fall pulses, which are registered on the same edge that updates the level.
//
// Parameters:
//   WIDTH        - number of GPIO bits conditioned
//   PRESCALE     - clk cycles per debounce sample tick (1..2^20)
//   STABLE_COUNT - consecutive disagreeing ticks needed before a bit changes
//                  (1..255)
//   RESET_VALUE  - reset level of the synchronizer flops and o_gpio
//                  (low WIDTH bits used)
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous, active-high reset. It must be released
//                synchronously to clk, for example by an upstream reset bridge.
//   i_bypass   - 1 = skip debounce; o_gpio follows the synchronized input
//   i_raw      - raw pad inputs, asynchronous to clk
//   o_gpio     - debounced level (drives the GPIO slave's gpio_in)
//   o_rise     - 1-cycle pulse per bit on an o_gpio 0->1 transition
//   o_fall     - 1-cycle pulse per bit on an o_gpio 1->0 transition
//   o_changed  - 1-cycle pulse, OR of all rise/fall pulses
// -----------------------------------------------------------------------------
module gpio_input_conditioner #(
    parameter int          WIDTH        = 32,
    parameter int          PRESCALE     = 1000,
    parameter int          STABLE_COUNT = 4,
    parameter logic [31:0] RESET_VALUE  = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_bypass,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_gpio,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic             o_changed
);

    // The cast truncates RESET_VALUE to WIDTH bits, or zero-extends it if
    // WIDTH is larger than 32.
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

    // The prescaler needs at least one bit, even when PRESCALE == 1.
    localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    // The counter only has to reach STABLE_COUNT-1 before it is cleared, so
    // it can never wrap.
    localparam int              CNT_W    = $clog2(STABLE_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_gpio;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_changed;
    logic [PS_W-1:0]  r_ps_cnt;

    logic             w_tick;
    logic [WIDTH-1:0] w_gpio_next;

    // ------------------------------------------------------------------
    // Free-running sample-tick prescaler (independent of i_bypass)
    // ------------------------------------------------------------------
    assign w_tick = (r_ps_cnt == PS_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ps_cnt <= '0;
        end else if (w_tick) begin
            r_ps_cnt <= '0;
        end else begin
            r_ps_cnt <= r_ps_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit debounce: each bit has its own counter and shares only the tick
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_next;
            logic             w_level_next;

            always_comb begin
                w_cnt_next   = r_cnt;
                w_level_next = r_gpio[gi];
                if (i_bypass) begin
                    // In bypass, the counter is held at zero. Debounce then
                    // restarts cleanly when bypass is removed.
                    w_cnt_next   = '0;
                    w_level_next = r_sync2[gi];
                end else if (w_tick) begin
                    if (r_sync2[gi] == r_gpio[gi]) begin
                        // Any agreeing sample throws away partial progress.
                        w_cnt_next = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_cnt_next   = '0;
                        w_level_next = r_sync2[gi];
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_next;
                end
            end

            assign w_gpio_next[gi] = w_level_next;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Synchronizer, output level and edge pulses
    // ------------------------------------------------------------------
    // The pulses are derived from the next level against the current level.
    // They are registered on the same edge as o_gpio, so each pulse lines up
    // with its level change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= RST_VAL;
            r_sync2   <= RST_VAL;
            r_gpio    <= RST_VAL;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_gpio    <= w_gpio_next;
            r_rise    <= w_gpio_next & ~r_gpio;
            r_fall    <= ~w_gpio_next & r_gpio;
            r_changed <= |(w_gpio_next ^ r_gpio);
        end
    end

    assign o_gpio    = r_gpio;
    assign o_rise    = r_rise;
    assign o_fall    = r_fall;
    assign o_changed = r_changed;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_gpio_input_conditioner
//
// Testbench for gpio_input_conditioner. It uses two instances:
//   u_a : PRESCALE=1,  STABLE_COUNT=4 (latency, bounce, bypass, reset)
//   u_b : PRESCALE=10, STABLE_COUNT=2 (wide pattern with a prescaled tick)
// Expected level-change events go into a queue when the stimulus is driven.
// They are popped and compared whenever the DUT raises o_changed.
// -----------------------------------------------------------------------------
module tb_gpio_input_conditioner;

    typedef struct {
        logic [31:0] gpio;
        logic [31:0] rise;
        logic [31:0] fall;
        int          min_c;
        int          max_c;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        a_bypass;
    logic [31:0] a_raw;
    logic [31:0] a_gpio, a_rise, a_fall;
    logic        a_changed;

    logic        b_bypass;
    logic [31:0] b_raw;
    logic [31:0] b_gpio, b_rise, b_fall;
    logic        b_changed;

    exp_t        sb_q[$];
    logic [31:0] a_model;
    logic [31:0] b_model;
    int          n_checks = 0;
    int          n_fail   = 0;

    gpio_input_conditioner #(
        .WIDTH(32), .PRESCALE(1), .STABLE_COUNT(4), .RESET_VALUE(32'h0)
    ) u_a (
        .clk(clk), .rst(rst), .i_bypass(a_bypass), .i_raw(a_raw),
        .o_gpio(a_gpio), .o_rise(a_rise), .o_fall(a_fall), .o_changed(a_changed)
    );

    gpio_input_conditioner #(
        .WIDTH(32), .PRESCALE(10), .STABLE_COUNT(2), .RESET_VALUE(32'h0)
    ) u_b (
        .clk(clk), .rst(rst), .i_bypass(b_bypass), .i_raw(b_raw),
        .o_gpio(b_gpio), .o_rise(b_rise), .o_fall(b_fall), .o_changed(b_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    task automatic test_reset();
        n_checks++;
        if (a_gpio !== 32'h0 || (a_rise | a_fall) !== 32'h0 || a_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: gpio=%h rise=%h fall=%h chg=%b required all 0",
                     a_gpio, a_rise, a_fall, a_changed);
        end
        n_checks++;
        if (b_gpio !== 32'h0 || (b_rise | b_fall) !== 32'h0 || b_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: gpio=%h rise=%h fall=%h chg=%b required all 0",
                     b_gpio, b_rise, b_fall, b_changed);
        end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (a_gpio !== 32'h0 || (a_rise | a_fall) !== 32'h0 || a_changed !== 1'b0 ||
                b_gpio !== 32'h0 || (b_rise | b_fall) !== 32'h0 || b_changed !== 1'b0) begin
                n_fail++;
                $display("FAIL idle cycle %0d: a_gpio=%h a_chg=%b b_gpio=%h b_chg=%b required 0",
                         k, a_gpio, a_changed, b_gpio, b_changed);
            end
        end
        $display("reset: idle 20 cycles checked");
    endtask

    // ------------------------------------------------------------------
    task automatic test_latency();
        exp_t e;
        a_raw[0] = 1'b1;                    // captured by sync1 at edge 0
        a_model  = a_model | 32'h1;
        sb_q.push_back('{gpio: a_model, rise: 32'h1, fall: 32'h0, min_c: 5, max_c: 5});
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 4) begin
                n_checks++;
                if (a_gpio[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL latency_early: edge 4 gpio[0]=%b required 0", a_gpio[0]);
                end
            end
            if (a_changed) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL latency_unexpected: edge %0d gpio=%h rise=%h fall=%h required no change",
                             k, a_gpio, a_rise, a_fall);
                end else begin
                    e = sb_q.pop_front();
                    $display("latency: edge %0d gpio=%h rise=%h fall=%h", k, a_gpio, a_rise, a_fall);
                    if (a_gpio !== e.gpio || a_rise !== e.rise || a_fall !== e.fall ||
                        k < e.min_c || k > e.max_c) begin
                        n_fail++;
                        $display("FAIL latency_event: edge %0d gpio=%h rise=%h fall=%h required edge %0d gpio=%h rise=%h fall=%h",
                                 k, a_gpio, a_rise, a_fall, e.min_c, e.gpio, e.rise, e.fall);
                    end
                end
            end else begin
                n_checks++;
                if ((a_rise | a_fall) !== 32'h0) begin
                    n_fail++;
                    $display("FAIL latency_pulse: edge %0d rise=%h fall=%h with changed=0, required 0",
                             k, a_rise, a_fall);
                end
            end
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL latency_missing: %0d events outstanding, required 0", sb_q.size());
        end
        sb_q.delete();
    endtask

    // ------------------------------------------------------------------
    // raw[3] is high for edges 0..2, low at edge 3, then high again.
    // Four clean samples are taken at edges 6..9, so the output changes at edge 9.
    task automatic test_bounce();
        exp_t e;
        a_raw[3] = 1'b1;
        a_model  = a_model | 32'h8;
        sb_q.push_back('{gpio: a_model, rise: 32'h8, fall: 32'h0, min_c: 9, max_c: 9});
        for (int k = 0; k <= 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 8) begin
                n_checks++;
                if (a_gpio[3] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bounce_early: edge 8 gpio[3]=%b required 0", a_gpio[3]);
                end
            end
            if (a_changed) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bounce_unexpected: edge %0d gpio=%h rise=%h fall=%h required no change",
                             k, a_gpio, a_rise, a_fall);
                end else begin
                    e = sb_q.pop_front();
                    $display("bounce: edge %0d gpio=%h rise=%h fall=%h", k, a_gpio, a_rise, a_fall);
                    if (a_gpio !== e.gpio || a_rise !== e.rise || a_fall !== e.fall ||
                        k < e.min_c || k > e.max_c) begin
                        n_fail++;
                        $display("FAIL bounce_event: edge %0d gpio=%h rise=%h fall=%h required edge %0d gpio=%h rise=%h fall=%h",
                                 k, a_gpio, a_rise, a_fall, e.min_c, e.gpio, e.rise, e.fall);
                    end
                end
            end
            // Drive the value that sync1 captures at edge k+1.
            a_raw[3] = (k + 1 == 3) ? 1'b0 : 1'b1;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL bounce_missing: %0d events outstanding, required 0", sb_q.size());
        end
        sb_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Prescaled tick: the earliest possible change is at edge 12 and the
    // latest allowed is 2 + 10*2 = 22.
    task automatic test_wide();
        exp_t        e;
        logic [31:0] pat;
        for (int ph = 0; ph < 2; ph++) begin
            pat   = 32'hA5A5_A5A5;
            b_raw = (ph == 0) ? pat : 32'h0;
            sb_q.push_back('{gpio: b_raw, rise: (ph == 0) ? pat : 32'h0,
                             fall: (ph == 0) ? 32'h0 : pat, min_c: 12, max_c: 22});
            for (int k = 0; k <= 30; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (b_changed) begin
                    n_checks++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL wide_unexpected: edge %0d gpio=%h rise=%h fall=%h required no change",
                                 k, b_gpio, b_rise, b_fall);
                    end else begin
                        e = sb_q.pop_front();
                        b_model = e.gpio;
                        $display("wide: edge %0d gpio=%h rise=%h fall=%h", k, b_gpio, b_rise, b_fall);
                        if (b_gpio !== e.gpio || b_rise !== e.rise || b_fall !== e.fall ||
                            k < e.min_c || k > e.max_c) begin
                            n_fail++;
                            $display("FAIL wide_event: edge %0d gpio=%h rise=%h fall=%h required edge %0d..%0d gpio=%h rise=%h fall=%h",
                                     k, b_gpio, b_rise, b_fall, e.min_c, e.max_c, e.gpio, e.rise, e.fall);
                        end
                    end
                end else begin
                    n_checks++;
                    if ((b_rise | b_fall) !== 32'h0) begin
                        n_fail++;
                        $display("FAIL wide_pulse: edge %0d rise=%h fall=%h with changed=0, required 0",
                                 k, b_rise, b_fall);
                    end
                end
            end
            n_checks++;
            if (sb_q.size() != 0 || b_gpio !== b_raw) begin
                n_fail++;
                $display("FAIL wide_missing: %0d events outstanding gpio=%h, required 0 and %h",
                         sb_q.size(), b_gpio, b_raw);
            end
            sb_q.delete();
        end
    endtask

    // ------------------------------------------------------------------
    // In bypass, raw[7] toggles every 3 edges and o_gpio follows 2 edges later.
    // After leaving bypass, a new rise needs the full 4-tick debounce again.
    task automatic test_bypass();
        exp_t e;
        a_bypass = 1'b1;
        a_raw[7] = 1'b1;
        sb_q.push_back('{gpio: a_model | 32'h80, rise: 32'h80, fall: 32'h0,  min_c: 2,  max_c: 2});
        sb_q.push_back('{gpio: a_model,          rise: 32'h0,  fall: 32'h80, min_c: 5,  max_c: 5});
        sb_q.push_back('{gpio: a_model | 32'h80, rise: 32'h80, fall: 32'h0,  min_c: 8,  max_c: 8});
        sb_q.push_back('{gpio: a_model,          rise: 32'h0,  fall: 32'h80, min_c: 11, max_c: 11});
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) begin
                a_bypass = 1'b0;
                a_raw[7] = 1'b1;
                a_model  = a_model | 32'h80;
                sb_q.push_back('{gpio: a_model, rise: 32'h80, fall: 32'h0, min_c: 5, max_c: 5});
            end
            for (int k = 0; k <= 16; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (a_changed) begin
                    n_checks++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL bypass_unexpected: phase %0d edge %0d gpio=%h rise=%h fall=%h required no change",
                                 ph, k, a_gpio, a_rise, a_fall);
                    end else begin
                        e = sb_q.pop_front();
                        $display("bypass: phase %0d edge %0d gpio=%h rise=%h fall=%h", ph, k, a_gpio, a_rise, a_fall);
                        if (a_gpio !== e.gpio || a_rise !== e.rise || a_fall !== e.fall ||
                            k < e.min_c || k > e.max_c) begin
                            n_fail++;
                            $display("FAIL bypass_event: phase %0d edge %0d gpio=%h rise=%h fall=%h required edge %0d gpio=%h rise=%h fall=%h",
                                     ph, k, a_gpio, a_rise, a_fall, e.min_c, e.gpio, e.rise, e.fall);
                        end
                    end
                end
                if (ph == 0)
                    a_raw[7] = (k + 1 < 12) ? (((k + 1) / 3) % 2 == 0) : 1'b0;
            end
            n_checks++;
            if (sb_q.size() != 0) begin
                n_fail++;
                $display("FAIL bypass_missing: phase %0d %0d events outstanding, required 0", ph, sb_q.size());
            end
            sb_q.delete();
        end
    endtask

    // ------------------------------------------------------------------
    // Asserting reset part-way through debounce discards all progress. After
    // release, every high input needs a full 4-tick debounce again.
    task automatic test_reset_mid();
        exp_t e;
        a_raw[1] = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (a_changed !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_pre: edge %0d changed=%b required 0", k, a_changed);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (a_gpio !== 32'h0 || (a_rise | a_fall) !== 32'h0 || a_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: gpio=%h rise=%h fall=%h chg=%b required all 0",
                     a_gpio, a_rise, a_fall, a_changed);
        end
        $display("rstmid: async reset asserted, gpio=%h", a_gpio);
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        a_model = a_raw;
        sb_q.push_back('{gpio: a_raw, rise: a_raw, fall: 32'h0, min_c: 5, max_c: 5});
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_changed) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rstmid_unexpected: edge %0d gpio=%h rise=%h fall=%h required no change",
                             k, a_gpio, a_rise, a_fall);
                end else begin
                    e = sb_q.pop_front();
                    $display("rstmid: edge %0d gpio=%h rise=%h fall=%h", k, a_gpio, a_rise, a_fall);
                    if (a_gpio !== e.gpio || a_rise !== e.rise || a_fall !== e.fall ||
                        k < e.min_c || k > e.max_c) begin
                        n_fail++;
                        $display("FAIL rstmid_event: edge %0d gpio=%h rise=%h fall=%h required edge %0d gpio=%h rise=%h fall=%h",
                                 k, a_gpio, a_rise, a_fall, e.min_c, e.gpio, e.rise, e.fall);
                    end
                end
            end
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_missing: %0d events outstanding, required 0", sb_q.size());
        end
        sb_q.delete();
    endtask

    // ------------------------------------------------------------------
    initial begin
        rst      = 1'b1;
        a_bypass = 1'b0;
        b_bypass = 1'b0;
        a_raw    = 32'h0;
        b_raw    = 32'h0;
        a_model  = 32'h0;
        b_model  = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        test_latency();
        test_bounce();
        test_wide();
        test_bypass();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
